// File: rtl/gmux_hsck_ctrl_pkg.sv
// gmux_hsck_ctrl_pkg: shared types and constants for the GMUX_HSCK sequencer.
// Rev 1.0
`default_nettype none

package gmux_hsck_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    QUIESCE = 3'd1,
    SWITCH  = 3'd2,
    SETTLE  = 3'd3,
    ENABLE  = 3'd4,
    DONE_ST = 3'd5
  } state_e;

  // Quadrant bit positions within every 4-bit quadrant vector
  localparam int Q_TL = 3;
  localparam int Q_TR = 2;
  localparam int Q_BL = 1;
  localparam int Q_BR = 0;

  localparam logic STATIC_DEN = 1'b0;

endpackage

`default_nettype wire

// File: rtl/gmux_hsck_ctrl_wait_cnt.sv
// gmux_wait_cnt: loadable down-counter with zero flag, shared by quiesce and settle waits.
// Rev 1.0
`default_nettype none

module gmux_wait_cnt
  import gmux_hsck_ctrl_pkg::*;
#(
  parameter int CNT_W = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic             zero_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Load wins over decrement; the count saturates at zero
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

`default_nettype wire

// File: rtl/gmux_hsck_ctrl.sv
// gmux_hsck_ctrl: glitch-free source/quadrant change sequencer for one GMUX_HSCK.
// Rev 1.0
`default_nettype none

module gmux_hsck_ctrl
  import gmux_hsck_ctrl_pkg::*;
#(
  parameter int QUIESCE_CYCLES = 4,
  parameter int SETTLE_CYCLES  = 4,
  parameter int CNT_W          = 4
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       REQ_VALID,
  input  logic       REQ_SEL,
  input  logic [3:0] REQ_QMASK,
  output logic       REQ_READY,
  output logic       DONE,
  output logic       BUSY,
  output logic       CUR_SEL,
  output logic [3:0] CUR_QMASK,
  output logic       SSEL,
  output logic [3:0] Q_SEN,
  output logic [3:0] Q_DEN,
  output logic [3:0] Q_DYNEN,
  output logic [3:0] Q_VLP
);

  localparam logic [CNT_W-1:0] QLOAD = CNT_W'(QUIESCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] SLOAD = CNT_W'(SETTLE_CYCLES - 1);

  state_e     state_q, state_d;
  logic       nsel_q, nsel_d;
  logic [3:0] nmask_q, nmask_d;
  logic       ssel_q, ssel_d;
  logic       cur_sel_q, cur_sel_d;
  logic [3:0] cur_qmask_q, cur_qmask_d;
  logic [3:0] sen_q, sen_d;
  logic [3:0] vlp_q, vlp_d;
  logic       done_q, done_d;
  logic       busy_q, busy_d;
  logic       ready_q, ready_d;

  logic             cnt_load;
  logic [CNT_W-1:0] cnt_load_val;
  logic             cnt_dec;
  logic             cnt_zero;
  logic [3:0]       remove;

  gmux_wait_cnt #(
    .CNT_W(CNT_W)
  ) u_wait_cnt (
    .clk_i      (CLK),
    .rst_i      (RST),
    .load_i     (cnt_load),
    .load_val_i (cnt_load_val),
    .dec_i      (cnt_dec),
    .zero_o     (cnt_zero)
  );

  // Register updates are computed on the transition into a state, so every
  // output already shows that state's action while the state is current.
  always_comb begin
    state_d      = state_q;
    nsel_d       = nsel_q;
    nmask_d      = nmask_q;
    ssel_d       = ssel_q;
    cur_sel_d    = cur_sel_q;
    cur_qmask_d  = cur_qmask_q;
    sen_d        = sen_q;
    vlp_d        = vlp_q;
    cnt_load     = 1'b0;
    cnt_load_val = QLOAD;
    cnt_dec      = 1'b0;
    remove       = 4'h0;

    case (state_q)
      IDLE: begin
        if (REQ_VALID && ready_q) begin
          nsel_d  = REQ_SEL;
          nmask_d = REQ_QMASK;
          if ((REQ_SEL == cur_sel_q) && (REQ_QMASK == cur_qmask_q)) begin
            state_d = DONE_ST;
          end else begin
            remove   = (REQ_SEL != cur_sel_q) ? cur_qmask_q : (cur_qmask_q & ~REQ_QMASK);
            sen_d    = sen_q & ~remove;
            vlp_d    = vlp_q & ~REQ_QMASK;
            cnt_load = 1'b1;
            state_d  = QUIESCE;
          end
        end
      end
      QUIESCE: begin
        cnt_dec = 1'b1;
        if (cnt_zero) begin
          if (nsel_q != cur_sel_q) begin
            ssel_d    = nsel_q;
            cur_sel_d = nsel_q;
            state_d   = SWITCH;
          end else begin
            sen_d       = nmask_q;
            vlp_d       = ~nmask_q;
            cur_qmask_d = nmask_q;
            state_d     = ENABLE;
          end
        end
      end
      SWITCH: begin
        cnt_load     = 1'b1;
        cnt_load_val = SLOAD;
        state_d      = SETTLE;
      end
      SETTLE: begin
        cnt_dec = 1'b1;
        if (cnt_zero) begin
          sen_d       = nmask_q;
          vlp_d       = ~nmask_q;
          cur_qmask_d = nmask_q;
          state_d     = ENABLE;
        end
      end
      ENABLE:  state_d = DONE_ST;
      DONE_ST: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    done_d  = (state_d == DONE_ST);
    busy_d  = (state_d != IDLE);
    ready_d = (state_d == IDLE);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= IDLE;
      nsel_q      <= 1'b0;
      nmask_q     <= 4'h0;
      ssel_q      <= 1'b0;
      cur_sel_q   <= 1'b0;
      cur_qmask_q <= 4'h0;
      sen_q       <= 4'h0;
      vlp_q       <= 4'hF;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
      ready_q     <= 1'b1;
    end else begin
      state_q     <= state_d;
      nsel_q      <= nsel_d;
      nmask_q     <= nmask_d;
      ssel_q      <= ssel_d;
      cur_sel_q   <= cur_sel_d;
      cur_qmask_q <= cur_qmask_d;
      sen_q       <= sen_d;
      vlp_q       <= vlp_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
      ready_q     <= ready_d;
    end
  end

  assign REQ_READY = ready_q;
  assign DONE      = done_q;
  assign BUSY      = busy_q;
  assign CUR_SEL   = cur_sel_q;
  assign CUR_QMASK = cur_qmask_q;
  assign SSEL      = ssel_q;
  assign Q_SEN     = sen_q;
  assign Q_VLP     = vlp_q;
  assign Q_DEN     = {4{STATIC_DEN}};
  assign Q_DYNEN   = {4{STATIC_DEN}};

endmodule

`default_nettype wire

// File: tb/tb_gmux_hsck_ctrl.sv
// tb_gmux_hsck_ctrl: directed self-checking bench for the GMUX_HSCK sequencer.
// Rev 1.0
`default_nettype none

module tb_gmux_hsck_ctrl;

  logic       CLK;
  logic       RST;
  logic       REQ_VALID;
  logic       REQ_SEL;
  logic [3:0] REQ_QMASK;
  logic       REQ_READY;
  logic       DONE;
  logic       BUSY;
  logic       CUR_SEL;
  logic [3:0] CUR_QMASK;
  logic       SSEL;
  logic [3:0] Q_SEN;
  logic [3:0] Q_DEN;
  logic [3:0] Q_DYNEN;
  logic [3:0] Q_VLP;

  int checks   = 0;
  int failures = 0;
  int inv_bad  = 0;
  int lat;

  logic [3:0] tr_sen  [0:63];
  logic       tr_ssel [0:63];
  logic [3:0] tr_vlp  [0:63];

  logic       p_ssel = 1'b0;
  logic [3:0] p_sen  = 4'h0;
  logic [3:0] p_vlp  = 4'hF;

  gmux_hsck_ctrl dut (
    .CLK       (CLK),
    .RST       (RST),
    .REQ_VALID (REQ_VALID),
    .REQ_SEL   (REQ_SEL),
    .REQ_QMASK (REQ_QMASK),
    .REQ_READY (REQ_READY),
    .DONE      (DONE),
    .BUSY      (BUSY),
    .CUR_SEL   (CUR_SEL),
    .CUR_QMASK (CUR_QMASK),
    .SSEL      (SSEL),
    .Q_SEN     (Q_SEN),
    .Q_DEN     (Q_DEN),
    .Q_DYNEN   (Q_DYNEN),
    .Q_VLP     (Q_VLP)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Safety monitor: SSEL only moves with all quadrants stopped, a quadrant
  // only starts after a cycle powered up, DEN/DYNEN stay low.
  always @(negedge CLK) begin
    if (!RST) begin
      if ((SSEL !== p_ssel) && ((Q_SEN != 4'h0) || (p_sen != 4'h0))) inv_bad++;
      if ((Q_SEN & ~p_sen & p_vlp) != 4'h0) inv_bad++;
      if ((Q_DEN != 4'h0) || (Q_DYNEN != 4'h0)) inv_bad++;
    end
    p_ssel = SSEL;
    p_sen  = Q_SEN;
    p_vlp  = Q_VLP;
  end

  // Issue one request; trace index k is the k-th falling edge after the
  // accept edge, and lat is the first k with DONE high (0 = never seen).
  task automatic run_req(input logic sel, input logic [3:0] mask, input bit poke);
    lat = 0;
    @(negedge CLK);
    REQ_VALID = 1'b1;
    REQ_SEL   = sel;
    REQ_QMASK = mask;
    @(posedge CLK);
    for (int k = 1; (k <= 40) && (lat == 0); k++) begin
      @(negedge CLK);
      REQ_VALID  = 1'b0;
      tr_sen[k]  = Q_SEN;
      tr_ssel[k] = SSEL;
      tr_vlp[k]  = Q_VLP;
      if (k == 1) check_eq("ready_drop", {31'd0, REQ_READY}, 32'd0);
      if (DONE) lat = k;
      if (poke && (k >= 2) && (k <= 3)) begin
        check_eq("ready_busy", {31'd0, REQ_READY}, 32'd0);
        REQ_VALID = 1'b1;
        REQ_SEL   = ~sel;
        REQ_QMASK = ~mask;
      end
    end
    REQ_VALID = 1'b0;
  endtask

  initial begin
    RST       = 1'b1;
    REQ_VALID = 1'b0;
    REQ_SEL   = 1'b0;
    REQ_QMASK = 4'h0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    check_eq("rst_ssel",  {31'd0, SSEL},      32'd0);
    check_eq("rst_sen",   {28'd0, Q_SEN},     32'h0);
    check_eq("rst_vlp",   {28'd0, Q_VLP},     32'hF);
    check_eq("rst_ready", {31'd0, REQ_READY}, 32'd1);
    check_eq("rst_busy",  {31'd0, BUSY},      32'd0);
    RST = 1'b0;

    // Bring-up from reset: GHSCK, all quadrants
    run_req(1'b1, 4'hF, 1'b0);
    check_eq("up_lat",      lat,                    32'd11);
    check_eq("up_vlp1",     {28'd0, tr_vlp[1]},     32'h0);
    check_eq("up_ssel4",    {31'd0, tr_ssel[4]},    32'd0);
    check_eq("up_ssel5",    {31'd0, tr_ssel[5]},    32'd1);
    check_eq("up_sen9",     {28'd0, tr_sen[9]},     32'h0);
    check_eq("up_sen10",    {28'd0, tr_sen[10]},    32'hF);
    check_eq("up_cur",      {27'd0, CUR_SEL, CUR_QMASK}, 32'h1F);

    // Mask-only shrink to TL/TR
    run_req(1'b1, 4'hC, 1'b0);
    check_eq("mo_lat",      lat,                    32'd6);
    check_eq("mo_sen1",     {28'd0, tr_sen[1]},     32'hC);
    check_eq("mo_sen4",     {28'd0, tr_sen[4]},     32'hC);
    check_eq("mo_ssel4",    {31'd0, tr_ssel[4]},    32'd1);
    check_eq("mo_vlp",      {28'd0, Q_VLP},         32'h3);
    check_eq("mo_cur",      {27'd0, CUR_SEL, CUR_QMASK}, 32'h1C);

    // Mask-only grow back to all quadrants
    run_req(1'b1, 4'hF, 1'b0);
    check_eq("mg_lat",      lat,                    32'd6);
    check_eq("mg_sen",      {28'd0, Q_SEN},         32'hF);

    // Source swap to GCLKIN with TR/BR
    run_req(1'b0, 4'h5, 1'b0);
    check_eq("sw_lat",      lat,                    32'd11);
    check_eq("sw_sen1",     {28'd0, tr_sen[1]},     32'h0);
    check_eq("sw_sen4",     {28'd0, tr_sen[4]},     32'h0);
    check_eq("sw_ssel4",    {31'd0, tr_ssel[4]},    32'd1);
    check_eq("sw_ssel5",    {31'd0, tr_ssel[5]},    32'd0);
    check_eq("sw_sen9",     {28'd0, tr_sen[9]},     32'h0);
    check_eq("sw_sen10",    {28'd0, tr_sen[10]},    32'h5);
    check_eq("sw_vlp",      {28'd0, Q_VLP},         32'hA);

    // Identical request is a no-op
    run_req(1'b0, 4'h5, 1'b0);
    check_eq("nop_lat",     lat,                    32'd1);
    check_eq("nop_out",     {23'd0, SSEL, Q_SEN, Q_VLP}, 32'h05A);

    // Mask change with an extra request while busy
    run_req(1'b0, 4'hA, 1'b1);
    check_eq("bz_lat",      lat,                    32'd6);
    check_eq("bz_sen1",     {28'd0, tr_sen[1]},     32'h0);
    check_eq("bz_out",      {23'd0, SSEL, Q_SEN, Q_VLP}, 32'h0A5);
    repeat (5) @(negedge CLK);
    check_eq("bz_idle",     {30'd0, BUSY, DONE},    32'd0);
    check_eq("bz_cur",      {27'd0, CUR_SEL, CUR_QMASK}, 32'h0A);

    // Empty mask: everything off and powered down
    run_req(1'b0, 4'h0, 1'b0);
    check_eq("z_lat",       lat,                    32'd6);
    check_eq("z_out",       {23'd0, SSEL, Q_SEN, Q_VLP}, 32'h00F);

    // Reset during SETTLE of a source change
    @(negedge CLK);
    REQ_VALID = 1'b1;
    REQ_SEL   = 1'b1;
    REQ_QMASK = 4'hF;
    @(posedge CLK);
    @(negedge CLK);
    REQ_VALID = 1'b0;
    repeat (5) @(negedge CLK);
    check_eq("ms_busy",     {31'd0, BUSY},          32'd1);
    check_eq("ms_ssel",     {31'd0, SSEL},          32'd1);
    RST = 1'b1;
    @(negedge CLK);
    check_eq("ms_rst_out",  {22'd0, SSEL, CUR_SEL, Q_SEN, Q_VLP}, 32'h00F);
    check_eq("ms_rst_st",   {25'd0, BUSY, DONE, REQ_READY, CUR_QMASK}, 32'h10);
    RST = 1'b0;

    run_req(1'b1, 4'hF, 1'b0);
    check_eq("ms_re_lat",   lat,                    32'd11);
    check_eq("ms_re_out",   {23'd0, SSEL, Q_SEN, Q_VLP}, 32'h1F0);

    check_eq("invariants",  inv_bad,                32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
